// File: rtl/cdb_arbiter.sv
// cdb_arbiter: rotating-priority scheduler driving the registered common data bus lanes.
// Define CDB_DUAL_LANE_EN for two broadcast lanes per cycle; otherwise lane 2 is tied off.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROB_W = 6,
  parameter int DATA_W = 32,
  parameter logic [ROB_W-1:0] INVALID_ROB = ROB_W'(6'b010000)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      cdb_iscast,
  output logic [ROB_W-1:0]          cdb_rob,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_iscast2,
  output logic [ROB_W-1:0]          cdb_rob2,
  output logic [DATA_W-1:0]         cdb_data2
);

  localparam int PTR_W = $clog2(NUM_REQ);

`ifdef CDB_DUAL_LANE_EN
  localparam bit DUAL_LANE_EN = 1'b1;
`else
  localparam bit DUAL_LANE_EN = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  logic [ROB_W-1:0]  rob_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rob_arr[gi]  = req_rob[gi*ROB_W +: ROB_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cast1_q, cast1_d, cast2_q, cast2_d;
  logic [ROB_W-1:0]  rob1_q, rob1_d, rob2_q, rob2_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;

  logic [NUM_REQ-1:0] rot_valid;
  logic               l1_hit, l2_hit, l1_win, l2_win, grant_en;
  logic [PTR_W-1:0]   l1_off, l2_off, l1_idx, l2_idx;

  // Offsets are relative to rr_ptr, so lane 2 can never wrap past it.
  always_comb begin
    rot_valid = '0;
    l1_hit    = 1'b0;
    l1_off    = '0;
    l2_hit    = 1'b0;
    l2_off    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot_valid[i] = req_valid[wrap_add(rr_ptr_q, i)];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!l1_hit && rot_valid[i]) begin
        l1_hit = 1'b1;
        l1_off = PTR_W'(i);
      end
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      if (l1_hit && !l2_hit && rot_valid[i] && (PTR_W'(i) > l1_off)) begin
        l2_hit = 1'b1;
        l2_off = PTR_W'(i);
      end
    end
    l1_idx   = wrap_add(rr_ptr_q, 32'(l1_off));
    l2_idx   = wrap_add(rr_ptr_q, 32'(l2_off));
    grant_en = !flush && !cdb_stall && !reset;
    l1_win   = l1_hit && grant_en;
    l2_win   = l2_hit && grant_en && DUAL_LANE_EN;
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign req_ack[gi] = (l1_win && (l1_idx == PTR_W'(gi))) ||
                         (l2_win && (l2_idx == PTR_W'(gi)));
  end

  // Idle lanes keep their data; with one lane, lane 2 never wins and stays at reset values.
  always_comb begin
    cast1_d  = l1_win;
    rob1_d   = l1_win ? rob_arr[l1_idx] : INVALID_ROB;
    data1_d  = l1_win ? data_arr[l1_idx] : data1_q;
    cast2_d  = l2_win;
    rob2_d   = l2_win ? rob_arr[l2_idx] : INVALID_ROB;
    data2_d  = l2_win ? data_arr[l2_idx] : data2_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (l2_win) begin
      rr_ptr_d = wrap_add(l2_idx, 1);
    end else if (l1_win) begin
      rr_ptr_d = wrap_add(l1_idx, 1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cast1_q  <= 1'b0;
      rob1_q   <= INVALID_ROB;
      data1_q  <= '0;
      cast2_q  <= 1'b0;
      rob2_q   <= INVALID_ROB;
      data2_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cast1_q  <= cast1_d;
      rob1_q   <= rob1_d;
      data1_q  <= data1_d;
      cast2_q  <= cast2_d;
      rob2_q   <= rob2_d;
      data2_q  <= data2_d;
    end
  end

  assign cdb_iscast  = cast1_q;
  assign cdb_rob     = rob1_q;
  assign cdb_data    = data1_q;
  assign cdb_iscast2 = cast2_q;
  assign cdb_rob2    = rob2_q;
  assign cdb_data2   = data2_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow CDB_DUAL_LANE_EN when it is defined.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int RW = 6;
  localparam int DW = 32;
  localparam logic [5:0] INV = 6'b010000;
`ifdef CDB_DUAL_LANE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset, flush, cdb_stall;
  logic [N-1:0]   req_valid, req_ack;
  logic [N*RW-1:0] req_rob;
  logic [N*DW-1:0] req_data;
  logic           cdb_iscast, cdb_iscast2;
  logic [RW-1:0]  cdb_rob, cdb_rob2;
  logic [DW-1:0]  cdb_data, cdb_data2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .flush(flush), .cdb_stall(cdb_stall),
    .req_valid(req_valid), .req_rob(req_rob), .req_data(req_data), .req_ack(req_ack),
    .cdb_iscast(cdb_iscast), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .cdb_iscast2(cdb_iscast2), .cdb_rob2(cdb_rob2), .cdb_data2(cdb_data2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_lanes(input string tag,
                           input logic c1, input logic [5:0] r1, input logic [31:0] d1,
                           input logic c2, input logic [5:0] r2, input logic [31:0] d2);
    chk({tag, ".cast1"}, 32'(cdb_iscast), 32'(c1));
    chk({tag, ".rob1"}, 32'(cdb_rob), 32'(r1));
    chk({tag, ".data1"}, cdb_data, d1);
    chk({tag, ".cast2"}, 32'(cdb_iscast2), 32'(c2));
    chk({tag, ".rob2"}, 32'(cdb_rob2), 32'(r2));
    chk({tag, ".data2"}, cdb_data2, d2);
  endtask

  task automatic set_req(input int k, input logic [5:0] r, input logic [31:0] d);
    req_rob[k*RW +: RW]  = r;
    req_data[k*DW +: DW] = d;
  endtask

  // Drive on the falling edge, check ack mid-cycle, check lanes just after the rising edge.
  task automatic step(input string tag, input logic [3:0] v, input logic fl, input logic st,
                      input logic [3:0] ea,
                      input logic c1, input logic [5:0] r1, input logic [31:0] d1,
                      input logic c2, input logic [5:0] r2, input logic [31:0] d2);
    @(negedge clock);
    req_valid = v;
    flush     = fl;
    cdb_stall = st;
    #1;
    chk({tag, ".ack"}, 32'(req_ack), 32'(ea));
    @(posedge clock);
    #1;
    chk_lanes(tag, c1, r1, d1, c2, r2, d2);
    $display("%-14s valid=%b flush=%b stall=%b ack=%b lane1=%b/%0d/%h lane2=%b/%0d/%h",
             tag, v, fl, st, req_ack, cdb_iscast, cdb_rob, cdb_data,
             cdb_iscast2, cdb_rob2, cdb_data2);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'b1111;
    req_rob   = '0;
    req_data  = '0;
    for (int k = 0; k < N; k++) set_req(k, 6'(8 + k), 32'hA0 + 32'(k));
    set_req(0, 6'd5, 32'h1234);

    #12;
    chk("reset.ack", 32'(req_ack), 32'd0);
    chk_lanes("reset", 1'b0, INV, 32'h0, 1'b0, INV, 32'h0);
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 4'b0000;

    step("single", 4'b0001, 1'b0, 1'b0, 4'b0001,
         1'b1, 6'd5, 32'h1234, 1'b0, INV, 32'h0);
    step("flush_idle", 4'b0000, 1'b1, 1'b0, 4'b0000,
         1'b0, INV, 32'h1234, 1'b0, INV, 32'h0);
    set_req(0, 6'd8, 32'hA0);

    step("all4_c1", 4'b1111, 1'b0, 1'b0, DUAL ? 4'b0011 : 4'b0001,
         1'b1, 6'd8, 32'hA0, DUAL, DUAL ? 6'd9 : INV, DUAL ? 32'hA1 : 32'h0);
    step("all4_c2", 4'b1110, 1'b0, 1'b0, DUAL ? 4'b1100 : 4'b0010,
         1'b1, DUAL ? 6'd10 : 6'd9, DUAL ? 32'hA2 : 32'hA1,
         DUAL, DUAL ? 6'd11 : INV, DUAL ? 32'hA3 : 32'h0);
    step("all4_c3", 4'b1100, 1'b0, 1'b0, DUAL ? 4'b1100 : 4'b0100,
         1'b1, 6'd10, 32'hA2, DUAL, DUAL ? 6'd11 : INV, DUAL ? 32'hA3 : 32'h0);
    step("all4_c4", 4'b1000, 1'b0, 1'b0, 4'b1000,
         1'b1, 6'd11, 32'hA3, 1'b0, INV, DUAL ? 32'hA3 : 32'h0);

    step("rr_to_2", 4'b0010, 1'b0, 1'b0, 4'b0010,
         1'b1, 6'd9, 32'hA1, 1'b0, INV, DUAL ? 32'hA3 : 32'h0);
    step("wrap", 4'b1010, 1'b0, 1'b0, DUAL ? 4'b1010 : 4'b1000,
         1'b1, 6'd11, 32'hA3, DUAL, DUAL ? 6'd9 : INV, DUAL ? 32'hA1 : 32'h0);
    step("rr_check", 4'b0101, 1'b0, 1'b0, DUAL ? 4'b0101 : 4'b0001,
         1'b1, DUAL ? 6'd10 : 6'd8, DUAL ? 32'hA2 : 32'hA0,
         DUAL, DUAL ? 6'd8 : INV, DUAL ? 32'hA0 : 32'h0);

    for (int c = 0; c < 3; c++) begin
      step($sformatf("stall%0d", c), 4'b0100, 1'b0, 1'b1, 4'b0000,
           1'b0, INV, DUAL ? 32'hA2 : 32'hA0, 1'b0, INV, DUAL ? 32'hA0 : 32'h0);
    end
    step("stall_rel", 4'b0100, 1'b0, 1'b0, 4'b0100,
         1'b1, 6'd10, 32'hA2, 1'b0, INV, DUAL ? 32'hA0 : 32'h0);

    step("flush", 4'b0011, 1'b1, 1'b0, 4'b0000,
         1'b0, INV, 32'hA2, 1'b0, INV, DUAL ? 32'hA0 : 32'h0);
    step("post_flush", 4'b1001, 1'b0, 1'b0, DUAL ? 4'b1001 : 4'b0001,
         1'b1, 6'd8, 32'hA0, DUAL, DUAL ? 6'd11 : INV, DUAL ? 32'hA3 : 32'h0);

    // Asynchronous reset pulse between edges while lane 1 is broadcasting.
    @(negedge clock);
    req_valid = 4'b1111;
    #1 reset = 1'b1;
    #1;
    chk("areset.ack", 32'(req_ack), 32'd0);
    chk_lanes("areset", 1'b0, INV, 32'h0, 1'b0, INV, 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("post_reset.ack", 32'(req_ack), DUAL ? 32'b0011 : 32'b0001);
    @(posedge clock);
    #1;
    chk_lanes("post_reset", 1'b1, 6'd8, 32'hA0, DUAL, DUAL ? 6'd9 : INV, DUAL ? 32'hA1 : 32'h0);
    $display("%-14s valid=%b ack after reset, lane1=%b/%0d/%h", "post_reset", req_valid,
             cdb_iscast, cdb_rob, cdb_data);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-bus scheduler between the execution-side reservation stations (ALU, load/store, branch, spare) and the common data bus. It accepts finished results from up to NUM_REQ requesters, grants at most two per cycle with rotating priority, and drives the registered CDB broadcast pairs (iscast/robNum/data) consumed by every reservation station and the ROB. Each accepted result is broadcast exactly once.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ROB_W, 6, ROB tag width.
- DATA_W, 32, result width.
- INVALID_ROB, 6'b010000, tag driven when a lane is idle.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous mispredict flush; drops the current cycle's requests and clears the broadcast registers.
- cdb_stall  in  1  ROB back-pressure; no grants while high.
- req_valid  in  NUM_REQ  result pending, one bit per requester.
- req_rob  in  NUM_REQ*ROB_W  tag of requester k in bits [k*ROB_W +: ROB_W].
- req_data  in  NUM_REQ*DATA_W  result of requester k in bits [k*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  combinational grant; transfer occurs at the clock edge where valid and ack are both high.
- cdb_iscast  out  1  lane-1 broadcast valid, registered.
- cdb_rob  out  ROB_W  lane-1 tag, registered.
- cdb_data  out  DATA_W  lane-1 result, registered.
- cdb_iscast2  out  1  lane-2 broadcast valid, registered.
- cdb_rob2  out  ROB_W  lane-2 tag, registered.
- cdb_data2  out  DATA_W  lane-2 result, registered.

## Operation
- State: rr_ptr (clog2(NUM_REQ) bits), plus the six lane output registers.
- Grant search, combinational: lane 1 goes to the first valid requester at index rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Lane 2 goes to the next valid requester after the lane-1 winner, searched the same way and stopping before it wraps back to rr_ptr.
- A requester wins at most one lane per cycle.
- req_ack[k] is high only for the lane winners, and only when flush=0 and cdb_stall=0.
- Requester handshake:
  - Requesters hold valid, rob and data stable until acked.
  - Dropping valid without an ack is legal: the request is withdrawn.
  - A requester may present a new result in the cycle after its ack.
- Lane registers at each edge:
  - Lane with a winner: iscast=1, rob and data copied from the winner.
  - Lane without a winner: iscast=0, rob=INVALID_ROB, data held.
- rr_ptr update:
  - Advances to (last granted index + 1) mod NUM_REQ.
  - Unchanged when there is no grant, cdb_stall=1, or flush=0 with no valid requests.
- Starvation bound: a continuously valid requester is acked within NUM_REQ-1 cycles with one lane, or within ceil((NUM_REQ-1)/2) cycles with two lanes, counted while cdb_stall=0.
- flush: acks are forced to 0 that cycle. At the edge, both iscast go to 0, both robs go to INVALID_ROB, and rr_ptr goes to 0.
- flush and cdb_stall together: flush behaviour applies.
- Back-to-back broadcasts leave iscast high across consecutive cycles. Consumers sample the lanes at the rising clock edge; they do not edge-detect iscast.
- Consumers must apply lane 1 and lane 2 independently in the same cycle; the two lanes never carry the same tag.

## Timing
- Reset (asynchronous, any time): cdb_iscast=0, cdb_iscast2=0, cdb_rob=cdb_rob2=INVALID_ROB, cdb_data=cdb_data2=0, rr_ptr=0.
- req_ack is 0 while reset is high. Reset mid-transfer discards the result, and the requester must not treat it as acked.
- Grant path: combinational from req_valid, rr_ptr, flush and cdb_stall to req_ack, within the same cycle.
- Latency: a result acked at edge N is visible on its lane from edge N until edge N+1. Each lane carries one result per cycle.
- Throughput: 2 results per cycle with two lanes, 1 per cycle with one lane.
- cdb_stall asserted: no new grants. Lanes already broadcasting for the current cycle complete normally; at the next edge both iscast go to 0.

## Configuration
- CDB_DUAL_LANE_EN defined: both lanes are active as described above.
- CDB_DUAL_LANE_EN undefined:
  - Lane 2 is tied off: cdb_iscast2=0, cdb_rob2=INVALID_ROB, cdb_data2=0.
  - At most one req_ack bit is high per cycle.
  - rr_ptr advances to (lane-1 winner + 1) mod NUM_REQ.

## Test plan
- Reset released, then req_valid=4'b0001 with rob=5 and data=32'h1234: req_ack=4'b0001 in the same cycle; after the edge cdb_iscast=1, cdb_rob=5, cdb_data=32'h1234, and cdb_iscast2=0.
- All four requesters valid with rr_ptr=0, held for 2 cycles (dual lane): acks are 4'b0011 and then 4'b1100, with broadcasts (0,1) then (2,3). In single-lane mode the acks are 0001, 0010, 0100, 1000.
- Requesters 1 and 3 valid with rr_ptr=2: lane 1 carries requester 3 and lane 2 carries requester 1 (wrap-around); rr_ptr becomes 2.
- cdb_stall=1 for 3 cycles with requester 2 valid: req_ack=0 and iscast is 0 after the first edge. On release, requester 2 is acked in that same cycle with its data unchanged.
- Broadcast pending plus flush=1 with two requests valid: acks are 0; at the next edge both iscast=0, both robs=INVALID_ROB, and rr_ptr=0.
- Async reset pulse mid-cycle while cdb_iscast=1: outputs return to reset values immediately, and the next grant after reset starts from requester 0.
